// File: rtl/rv32_decode_stage.sv
// rtl/rv32_decode_stage.sv - registered RV32I decode stage with 2-entry skid buffer
//
// Decodes one fetched RV32I instruction per cycle into register indices, a
// sign-extended immediate, an ALU operation and control strobes.
// The decoded bundle is held in an output register backed by one skid entry,
// so the stage sustains full throughput under backpressure while in_ready
// stays a pure register output.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   flush              drop everything held and anything accepted this cycle
//   in_valid/in_ready  fetch-side handshake; in_instr, in_pc are the payload
//   out_valid/out_ready execute-side handshake; out_* are the decoded bundle
//   ill_count          saturating count of illegal bundles handed to execute

module rv32_decode_stage #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [2:0]           out_funct3,
  output logic [31:0]          out_imm,
  output logic [3:0]           out_alu_op,
  output logic                 out_alu_src_imm,
  output logic                 out_reg_write,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_branch,
  output logic                 out_jump,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [31:0]     imm;
    logic [3:0]      alu_op;
    logic            alu_src_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  // funct3 -> ALU op when bit 30 does not select the alternate (SUB/SRA) form.
  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction fields and the candidate immediates of every format.
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd_f   = in_instr[11:7];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_sh = {27'b0, in_instr[24:20]};

  bundle_t dec;

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.rd     = rd_f;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct3 = funct3;
    dec.alu_op = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (in_instr[30] && funct3 == 3'b000)      dec.alu_op = ALU_SUB;
        else if (in_instr[30] && funct3 == 3'b101) dec.alu_op = ALU_SRA;
        else                                       dec.alu_op = alu_base(funct3);
        dec.reg_write = 1'b1;
        dec.illegal   = !((funct7 == 7'h00) ||
                          (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_IMM: begin
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift amount lives in [24:20]; [31:25] is a funct7-style qualifier.
          dec.imm     = imm_sh;
          dec.alu_op  = (funct3 == 3'b101 && in_instr[30]) ? ALU_SRA : alu_base(funct3);
          dec.illegal = (funct7 != 7'h00) && !(funct7 == 7'h20 && funct3 == 3'b101);
        end else begin
          // There is no SUBI: bit 30 is plain immediate data here.
          dec.imm    = imm_i;
          dec.alu_op = alu_base(funct3);
        end
      end
      OP_LOAD: begin
        dec.imm       = imm_i;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = (funct3 != 3'b010);
      end
      OP_STORE: begin
        dec.imm       = imm_s;
        dec.mem_write = 1'b1;
        dec.illegal   = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        dec.imm     = imm_b;
        dec.alu_op  = ALU_SUB;
        dec.branch  = 1'b1;
        dec.illegal = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        dec.imm       = imm_j;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        dec.imm         = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.jump        = 1'b1;
        dec.reg_write   = 1'b1;
        dec.illegal     = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec.imm         = imm_u;
        dec.alu_op      = ALU_PASSB;
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    // An illegal instruction must not produce any architectural side effect.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
    if (rd_f == 5'd0) dec.reg_write = 1'b0;
  end

  bundle_t               out_q;
  bundle_t               skid_q;
  logic                  out_v;
  logic                  skid_v;
  logic [ILL_CNT_W-1:0]  ill_q;

  // The output register is free when it is empty or being consumed this cycle.
  // The skid entry is only ever filled while the output is stalled, and it is
  // drained first whenever the output frees, so FIFO order is preserved and
  // in_ready (= skid empty) guarantees no accept happens while it is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
      ill_q  <= '0;
    end else if (flush) begin
      // Flush overrides every simultaneous accept, hand-off and count update.
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      if (out_v && out_ready && out_q.illegal && ill_q != '1)
        ill_q <= ill_q + 1'b1;
      if (!out_v || out_ready) begin
        if (skid_v) begin
          out_q  <= skid_q;
          out_v  <= 1'b1;
          skid_v <= 1'b0;
        end else if (in_valid) begin
          out_q <= dec;
          out_v <= 1'b1;
        end else begin
          out_v <= 1'b0;
        end
      end else if (in_valid && !skid_v) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end
  end

  assign in_ready        = !skid_v;
  assign out_valid       = out_v;
  assign out_pc          = out_q.pc;
  assign out_rd          = out_q.rd;
  assign out_rs1         = out_q.rs1;
  assign out_rs2         = out_q.rs2;
  assign out_funct3      = out_q.funct3;
  assign out_imm         = out_q.imm;
  assign out_alu_op      = out_q.alu_op;
  assign out_alu_src_imm = out_q.alu_src_imm;
  assign out_reg_write   = out_q.reg_write;
  assign out_mem_read    = out_q.mem_read;
  assign out_mem_write   = out_q.mem_write;
  assign out_branch      = out_q.branch;
  assign out_jump        = out_q.jump;
  assign out_illegal     = out_q.illegal;
  assign ill_count       = ill_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// tb/tb_rv32_decode_stage.sv - self-checking bench for rv32_decode_stage

module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic        out_alu_src_imm;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_branch;
  logic        out_jump;
  logic        out_illegal;
  logic [7:0]  ill_count;

  always #5 clk = ~clk;

  rv32_decode_stage #(.XLEN(32), .ILL_CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_alu_src_imm(out_alu_src_imm),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal), .ill_count(ill_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bund_t;

  // funct3 -> ALU code (ADD SLL SLT SLTU XOR SRL OR AND); the alternate
  // forms SUB and SRA sit one code above ADD and SRL.
  localparam int BASE_OP [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  int         vecs = 0;
  int         errs = 0;
  int         popped = 0;
  logic [7:0] mcnt = 8'd0;
  bund_t      q[$];

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic int alu_of(input int f3, input bit alt);
    int op = BASE_OP[f3];
    if (alt && (f3 == 0 || f3 == 5)) op = op + 1;
    return op;
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic bund_t model(input logic [31:0] w, input logic [31:0] pc);
    bund_t b;
    int f3 = int'(w[14:12]);
    int f7 = int'(w[31:25]);
    int imm_i = $signed(w) >>> 20;
    int imm_s = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
    int imm_b = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                + int'(w[11:8]) * 2;
    int imm_j = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                + int'(w[30:21]) * 2;
    int imm_u = int'(w & 32'hFFFFF000);
    int imm = 0;
    int alu = 0;
    bit src = 0, wr = 0, mr = 0, mw = 0, br = 0, jp = 0, ill = 0;
    case (w[6:0])
      7'h33: begin alu = alu_of(f3, w[30]); wr = 1;
                   ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))); end
      7'h13: begin
        src = 1; wr = 1; alu = alu_of(f3, w[30] && f3 == 5);
        if (f3 == 1 || f3 == 5) begin
          imm = int'(w[24:20]);
          ill = !(f7 == 0 || (f7 == 32 && f3 == 5));
        end else imm = imm_i;
      end
      7'h03: begin imm = imm_i; mr = 1; wr = 1; ill = (f3 != 2); end
      7'h23: begin imm = imm_s; mw = 1; ill = (f3 != 2); end
      7'h63: begin imm = imm_b; alu = 1; br = 1; ill = (f3 == 2 || f3 == 3); end
      7'h6F: begin imm = imm_j; jp = 1; wr = 1; end
      7'h67: begin imm = imm_i; src = 1; jp = 1; wr = 1; ill = (f3 != 0); end
      7'h37: begin imm = imm_u; alu = 10; src = 1; wr = 1; end
      default: ill = 1;
    endcase
    b.pc        = pc;
    b.rd        = w[11:7];
    b.rs1       = w[19:15];
    b.rs2       = w[24:20];
    b.f3        = w[14:12];
    b.imm       = imm;
    b.alu       = 4'(alu);
    b.src_imm   = src;
    b.reg_write = wr && !ill && (w[11:7] != 5'd0);
    b.mem_read  = mr && !ill;
    b.mem_write = mw && !ill;
    b.branch    = br && !ill;
    b.jump      = jp && !ill;
    b.illegal   = ill;
    return b;
  endfunction

  function automatic bund_t obs();
    bund_t b;
    b.pc = out_pc; b.rd = out_rd; b.rs1 = out_rs1; b.rs2 = out_rs2; b.f3 = out_funct3;
    b.imm = out_imm; b.alu = out_alu_op; b.src_imm = out_alu_src_imm;
    b.reg_write = out_reg_write; b.mem_read = out_mem_read; b.mem_write = out_mem_write;
    b.branch = out_branch; b.jump = out_jump; b.illegal = out_illegal;
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    w[6:0] = OPS[$urandom_range(0, 9)];
    if (w[6:0] == 7'h33 && ($urandom % 4) != 0) w[31:25] = ($urandom % 2) ? 7'h20 : 7'h00;
    if (w[6:0] == 7'h13 && ($urandom % 2) != 0) w[31:25] = ($urandom % 2) ? 7'h20 : 7'h00;
    if ((w[6:0] == 7'h03 || w[6:0] == 7'h23) && ($urandom % 2) != 0) w[14:12] = 3'b010;
    if (w[6:0] == 7'h67 && ($urandom % 2) != 0) w[14:12] = 3'b000;
    return w;
  endfunction

  // One clock: score the hand-off, advance the occupancy model, then check
  // the registered state one time unit after the edge.
  task automatic cyc(output bit acc);
    bit con, fl, stall;
    bund_t snap, e;
    logic [31:0] wi, pci;
    acc   = in_valid && in_ready;
    con   = out_valid && out_ready;
    stall = out_valid && !out_ready;
    fl    = flush;
    wi    = in_instr;
    pci   = in_pc;
    snap  = obs();
    if (con) begin
      chk("handoff_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("handoff_bundle", snap, e);
        popped++;
        if (!fl && e.illegal && mcnt != 8'hFF) mcnt++;
      end
    end
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else if (acc) q.push_back(model(wi, pci));
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("ill_count", ill_count, mcnt);
    if (q.size() > 0) chk("out_bundle", obs(), q[0]);
    if (stall && !fl) chk("stall_stable", obs(), snap);
  endtask

  initial begin
    bit a;
    int idx, p0;
    logic [7:0] c0;
    logic [31:0] list [4];

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'd0; in_pc = 32'd0;
    #12;
    chk("reset_bundle", obs(), 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_ill_count", ill_count, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,5
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
    cyc(a);
    chk("addi_rd", out_rd, 1); chk("addi_rs1", out_rs1, 0); chk("addi_imm", out_imm, 5);
    chk("addi_alu", out_alu_op, 0); chk("addi_src", out_alu_src_imm, 1);
    chk("addi_rw", out_reg_write, 1); chk("addi_ill", out_illegal, 0);
    // sub x3,x1,x2
    in_instr = 32'h402081B3; in_pc = 32'h104;
    cyc(a);
    chk("sub_alu", out_alu_op, 1); chk("sub_rd", out_rd, 3); chk("sub_rs1", out_rs1, 1);
    chk("sub_rs2", out_rs2, 2); chk("sub_rw", out_reg_write, 1); chk("sub_src", out_alu_src_imm, 0);
    // sw x2,-4(x1)
    in_instr = 32'hFE20AE23; in_pc = 32'h108;
    cyc(a);
    chk("sw_imm", out_imm, 32'hFFFFFFFC); chk("sw_mw", out_mem_write, 1);
    chk("sw_rw", out_reg_write, 0); chk("sw_rs1", out_rs1, 1); chk("sw_rs2", out_rs2, 2);
    // jal x1,-8
    in_instr = 32'hFF9FF0EF; in_pc = 32'h10C;
    cyc(a);
    chk("jal_imm", out_imm, 32'hFFFFFFF8); chk("jal_jump", out_jump, 1); chk("jal_rd", out_rd, 1);
    in_valid = 1'b0;
    cyc(a);

    // Four-instruction stream against a 3-cycle stall.
    list[0] = 32'h00100113; list[1] = 32'h00200193; list[2] = 32'h00300213; list[3] = 32'h00400293;
    idx = 0; p0 = popped;
    for (int k = 0; k < 12; k++) begin
      out_ready = (k >= 3);
      in_valid  = (idx < 4);
      in_instr  = (idx < 4) ? list[idx] : 32'd0;
      in_pc     = 32'h200 + 32'(idx * 4);
      cyc(a);
      if (a) idx++;
      if (k == 1) chk("skid_full_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("stream_accepted", idx, 4);
    chk("stream_emitted", popped - p0, 4);

    // Illegal instructions and the saturating counter.
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = 32'hFFFFFFFF; in_pc = 32'h300;
    cyc(a);
    chk("ill1_flag", out_illegal, 1);
    chk("ill1_strobes", {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump}, 0);
    in_instr = 32'h40109093; in_pc = 32'h304;
    cyc(a);
    chk("ill2_flag", out_illegal, 1);
    chk("ill2_strobes", {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump}, 0);
    in_valid = 1'b0;
    cyc(a);
    chk("ill_count_two", ill_count, 2);
    in_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      in_instr = {$urandom} & 32'hFFFFFF80 | 32'h0000000B;
      in_pc = 32'h400 + 32'(k * 4);
      cyc(a);
    end
    in_valid = 1'b0;
    cyc(a); cyc(a);
    chk("ill_count_sat", ill_count, 8'hFF);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00500093; cyc(a);
    in_instr = 32'hFFFFFFFF; cyc(a);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_bundle", obs(), 0);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_ill_count", ill_count, 0);
    q.delete(); mcnt = 8'd0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomised traffic with backpressure and occasional flushes.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = !out_ready && (($urandom % 25) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFFFFFC;
      cyc(a);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(a); cyc(a); cyc(a);

    // Flush with two held and one incoming.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hFFFFFFFF; cyc(a);
    in_instr = 32'h0000000B; cyc(a);
    c0 = mcnt;
    flush = 1'b1; in_instr = 32'h00700393;
    cyc(a);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1; p0 = popped;
    cyc(a); cyc(a); cyc(a);
    chk("flush_nothing_emitted", popped - p0, 0);
    chk("flush_ill_count", ill_count, c0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
